// File: rtl/sc_endgame_monitor_pkg.sv
// Shared game codes: main FSM state codes, monitor states and defaults.
// Imported by the end-game monitor, its interface and its edge detector.
package sc_game_pkg;

    typedef enum logic [1:0] {
        AWAIT_0 = 2'b00,
        GAME    = 2'b01,
        END     = 2'b10,
        AWAIT_1 = 2'b11
    } main_state_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        HIT  = 2'b10,
        OVER = 2'b11
    } mon_state_e;

    localparam int LIVES_INIT_DEF   = 3;
    localparam int TIME_INIT_DEF    = 30;
    localparam int GOALS_TO_WIN_DEF = 4;

endpackage

// File: rtl/sc_endgame_monitor_if.sv
// Bundle between the game side (main FSM, playfield) and the monitor.
// master drives game state and events; slave returns end-game and counters.
interface sc_endgame_monitor_if #(
    parameter int STATE_DATAWIDTH = 2,
    parameter int LIVES_WIDTH     = 2,
    parameter int TIME_WIDTH      = 6,
    parameter int GOAL_WIDTH      = 3
);
    logic [STATE_DATAWIDTH-1:0] SC_ENDGAME_MONITOR_MainState_In;
    logic                       SC_ENDGAME_MONITOR_LoadSignal_In;
    logic                       SC_ENDGAME_MONITOR_Tick_In;
    logic                       SC_ENDGAME_MONITOR_Collision_InLow;
    logic                       SC_ENDGAME_MONITOR_Goal_InLow;
    logic                       SC_ENDGAME_MONITOR_EndGameSignal_OutLow;
    logic                       SC_ENDGAME_MONITOR_Win_Out;
    logic                       SC_ENDGAME_MONITOR_Respawn_Out;
    logic [LIVES_WIDTH-1:0]     SC_ENDGAME_MONITOR_Lives_Out;
    logic [TIME_WIDTH-1:0]      SC_ENDGAME_MONITOR_Timer_Out;
    logic [GOAL_WIDTH-1:0]      SC_ENDGAME_MONITOR_Goals_Out;

    modport master (
        output SC_ENDGAME_MONITOR_MainState_In,
        output SC_ENDGAME_MONITOR_LoadSignal_In,
        output SC_ENDGAME_MONITOR_Tick_In,
        output SC_ENDGAME_MONITOR_Collision_InLow,
        output SC_ENDGAME_MONITOR_Goal_InLow,
        input  SC_ENDGAME_MONITOR_EndGameSignal_OutLow,
        input  SC_ENDGAME_MONITOR_Win_Out,
        input  SC_ENDGAME_MONITOR_Respawn_Out,
        input  SC_ENDGAME_MONITOR_Lives_Out,
        input  SC_ENDGAME_MONITOR_Timer_Out,
        input  SC_ENDGAME_MONITOR_Goals_Out
    );

    modport slave (
        input  SC_ENDGAME_MONITOR_MainState_In,
        input  SC_ENDGAME_MONITOR_LoadSignal_In,
        input  SC_ENDGAME_MONITOR_Tick_In,
        input  SC_ENDGAME_MONITOR_Collision_InLow,
        input  SC_ENDGAME_MONITOR_Goal_InLow,
        output SC_ENDGAME_MONITOR_EndGameSignal_OutLow,
        output SC_ENDGAME_MONITOR_Win_Out,
        output SC_ENDGAME_MONITOR_Respawn_Out,
        output SC_ENDGAME_MONITOR_Lives_Out,
        output SC_ENDGAME_MONITOR_Timer_Out,
        output SC_ENDGAME_MONITOR_Goals_Out
    );

endinterface

// File: rtl/sc_endgame_monitor_falledge.sv
// Falling-edge detector for an active-low level input.
// The pulse is combinational so the consumer acts on the same clock edge.
module sc_falledge_detector (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic fall_o
);
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign fall_o = prev_q & ~sig_i;

endmodule

// File: rtl/sc_endgame_monitor.sv
// End-game monitor: tracks lives, round timer and goals for the main FSM.
// Drives the active-low end-game level, win flag and respawn pulse.
module sc_endgame_monitor
    import sc_game_pkg::*;
#(
    parameter int STATE_DATAWIDTH = 2,
    parameter int LIVES_INIT      = LIVES_INIT_DEF,
    parameter int LIVES_WIDTH     = 2,
    parameter int TIME_INIT       = TIME_INIT_DEF,
    parameter int TIME_WIDTH      = 6,
    parameter int GOALS_TO_WIN    = GOALS_TO_WIN_DEF,
    parameter int GOAL_WIDTH      = 3,
    parameter int RESPAWN_CYCLES  = 4
) (
    input logic                   SC_ENDGAME_MONITOR_CLOCK_50,
    input logic                   SC_ENDGAME_MONITOR_RESET_InLow,
    sc_endgame_monitor_if.slave   bus
);
    localparam int HCW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

    localparam logic [LIVES_WIDTH-1:0] L_INIT = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [TIME_WIDTH-1:0]  T_INIT = TIME_WIDTH'(TIME_INIT);
    localparam logic [GOAL_WIDTH-1:0]  G_WIN  = GOAL_WIDTH'(GOALS_TO_WIN);
    localparam logic [HCW-1:0]         H_LAST = HCW'(RESPAWN_CYCLES - 1);

    mon_state_e            state_q;
    logic                  endgame_q;
    logic                  win_q;
    logic                  respawn_q;
    logic [LIVES_WIDTH-1:0] lives_q;
    logic [TIME_WIDTH-1:0]  timer_q;
    logic [GOAL_WIDTH-1:0]  goals_q;
    logic [HCW-1:0]         hcnt_q;

    logic coll_fall;
    logic goal_fall;
    logic timeout;
    logic life_loss;
    logic start;
    logic [GOAL_WIDTH-1:0] goals_inc;

    sc_falledge_detector u_coll_edge (
        .clk_i  (SC_ENDGAME_MONITOR_CLOCK_50),
        .rst_ni (SC_ENDGAME_MONITOR_RESET_InLow),
        .sig_i  (bus.SC_ENDGAME_MONITOR_Collision_InLow),
        .fall_o (coll_fall)
    );

    sc_falledge_detector u_goal_edge (
        .clk_i  (SC_ENDGAME_MONITOR_CLOCK_50),
        .rst_ni (SC_ENDGAME_MONITOR_RESET_InLow),
        .sig_i  (bus.SC_ENDGAME_MONITOR_Goal_InLow),
        .fall_o (goal_fall)
    );

    assign timeout   = bus.SC_ENDGAME_MONITOR_Tick_In &&
                       (timer_q == TIME_WIDTH'(1));
    assign life_loss = coll_fall || (timeout && !goal_fall);
    assign goals_inc = goals_q + GOAL_WIDTH'(1);
    assign start     = bus.SC_ENDGAME_MONITOR_LoadSignal_In &&
                       (bus.SC_ENDGAME_MONITOR_MainState_In ==
                        STATE_DATAWIDTH'(GAME));

    always_ff @(posedge SC_ENDGAME_MONITOR_CLOCK_50 or
                negedge SC_ENDGAME_MONITOR_RESET_InLow) begin
        if (!SC_ENDGAME_MONITOR_RESET_InLow) begin
            state_q   <= IDLE;
            endgame_q <= 1'b1;
            win_q     <= 1'b0;
            respawn_q <= 1'b0;
            lives_q   <= L_INIT;
            timer_q   <= T_INIT;
            goals_q   <= '0;
            hcnt_q    <= '0;
        end else begin
            respawn_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    endgame_q <= 1'b1;
                    win_q     <= 1'b0;
                    lives_q   <= L_INIT;
                    timer_q   <= T_INIT;
                    goals_q   <= '0;
                    if (start) state_q <= PLAY;
                end
                PLAY: begin
                    if (!bus.SC_ENDGAME_MONITOR_LoadSignal_In) begin
                        state_q <= IDLE;
                        lives_q <= L_INIT;
                        timer_q <= T_INIT;
                        goals_q <= '0;
                    end else if (life_loss) begin
                        if (lives_q > LIVES_WIDTH'(1)) begin
                            lives_q   <= lives_q - LIVES_WIDTH'(1);
                            timer_q   <= T_INIT;
                            respawn_q <= 1'b1;
                            hcnt_q    <= '0;
                            state_q   <= HIT;
                        end else begin
                            lives_q   <= '0;
                            endgame_q <= 1'b0;
                            win_q     <= 1'b0;
                            state_q   <= OVER;
                            if (timeout) timer_q <= '0;
                        end
                    end else if (goal_fall) begin
                        // Goal beats a same-cycle timeout: timer reloads
                        goals_q <= goals_inc;
                        timer_q <= T_INIT;
                        if (goals_inc >= G_WIN) begin
                            goals_q   <= G_WIN;
                            endgame_q <= 1'b0;
                            win_q     <= 1'b1;
                            state_q   <= OVER;
                        end else begin
                            respawn_q <= 1'b1;
                            hcnt_q    <= '0;
                            state_q   <= HIT;
                        end
                    end else if (bus.SC_ENDGAME_MONITOR_Tick_In) begin
                        timer_q <= timer_q - TIME_WIDTH'(1);
                    end
                end
                HIT: begin
                    if (!bus.SC_ENDGAME_MONITOR_LoadSignal_In) begin
                        state_q <= IDLE;
                        lives_q <= L_INIT;
                        timer_q <= T_INIT;
                        goals_q <= '0;
                    end else if (hcnt_q == H_LAST) begin
                        state_q <= PLAY;
                    end else begin
                        hcnt_q <= hcnt_q + HCW'(1);
                    end
                end
                OVER: begin
                    if (bus.SC_ENDGAME_MONITOR_MainState_In ==
                        STATE_DATAWIDTH'(AWAIT_0)) begin
                        state_q   <= IDLE;
                        endgame_q <= 1'b1;
                        win_q     <= 1'b0;
                        lives_q   <= L_INIT;
                        timer_q   <= T_INIT;
                        goals_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.SC_ENDGAME_MONITOR_EndGameSignal_OutLow = endgame_q;
    assign bus.SC_ENDGAME_MONITOR_Win_Out              = win_q;
    assign bus.SC_ENDGAME_MONITOR_Respawn_Out          = respawn_q;
    assign bus.SC_ENDGAME_MONITOR_Lives_Out            = lives_q;
    assign bus.SC_ENDGAME_MONITOR_Timer_Out            = timer_q;
    assign bus.SC_ENDGAME_MONITOR_Goals_Out            = goals_q;

endmodule

// File: tb/tb_sc_endgame_monitor.sv
// Directed bench for sc_endgame_monitor: vector table plus
// hand-written timeout, goal/timeout and asynchronous reset sequences.
module tb_sc_endgame_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sc_endgame_monitor_if #(
        .STATE_DATAWIDTH(2), .LIVES_WIDTH(2),
        .TIME_WIDTH(6), .GOAL_WIDTH(3)
    ) bus ();

    sc_endgame_monitor dut (
        .SC_ENDGAME_MONITOR_CLOCK_50   (clk),
        .SC_ENDGAME_MONITOR_RESET_InLow(rst_n),
        .bus                           (bus)
    );

    typedef struct {
        string    name;
        logic     ld;
        logic [1:0] st;
        logic     tick;
        logic     cn;
        logic     gn;
        int       e;
        int       w;
        int       r;
        int       l;
        int       t;
        int       g;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic ld,
                       input logic [1:0] st, input logic tick,
                       input logic cn, input logic gn,
                       input int e, input int w, input int r,
                       input int l, input int t, input int g);
        vec_t v;
        v.name = nm; v.ld = ld; v.st = st; v.tick = tick;
        v.cn = cn; v.gn = gn; v.e = e; v.w = w; v.r = r;
        v.l = l; v.t = t; v.g = g;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int e, input int w,
                           input int r, input int l, input int t,
                           input int g);
        chk({nm, ".endgame"}, int'(bus.SC_ENDGAME_MONITOR_EndGameSignal_OutLow), e);
        chk({nm, ".win"}, int'(bus.SC_ENDGAME_MONITOR_Win_Out), w);
        chk({nm, ".respawn"}, int'(bus.SC_ENDGAME_MONITOR_Respawn_Out), r);
        chk({nm, ".lives"}, int'(bus.SC_ENDGAME_MONITOR_Lives_Out), l);
        chk({nm, ".timer"}, int'(bus.SC_ENDGAME_MONITOR_Timer_Out), t);
        chk({nm, ".goals"}, int'(bus.SC_ENDGAME_MONITOR_Goals_Out), g);
    endtask

    task automatic step(input logic ld, input logic [1:0] st,
                        input logic tick, input logic cn, input logic gn);
        bus.SC_ENDGAME_MONITOR_LoadSignal_In   = ld;
        bus.SC_ENDGAME_MONITOR_MainState_In    = st;
        bus.SC_ENDGAME_MONITOR_Tick_In         = tick;
        bus.SC_ENDGAME_MONITOR_Collision_InLow = cn;
        bus.SC_ENDGAME_MONITOR_Goal_InLow      = gn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.SC_ENDGAME_MONITOR_LoadSignal_In   = 1'b0;
        bus.SC_ENDGAME_MONITOR_MainState_In    = 2'b00;
        bus.SC_ENDGAME_MONITOR_Tick_In         = 1'b0;
        bus.SC_ENDGAME_MONITOR_Collision_InLow = 1'b1;
        bus.SC_ENDGAME_MONITOR_Goal_InLow      = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, ld, st, tick, cn, gn | E W R L T G
        add("idle11",   0, 2'b11, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("start",    1, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("col1",     1, 2'b01, 0, 0, 1, 1, 0, 1, 2, 30, 0);
        add("hit_a",    1, 2'b01, 0, 1, 1, 1, 0, 0, 2, 30, 0);
        add("hit_col",  1, 2'b01, 0, 0, 1, 1, 0, 0, 2, 30, 0);
        add("hit_b",    1, 2'b01, 0, 0, 1, 1, 0, 0, 2, 30, 0);
        add("hit_c",    1, 2'b01, 0, 0, 1, 1, 0, 0, 2, 30, 0);
        add("held",     1, 2'b01, 1, 0, 1, 1, 0, 0, 2, 29, 0);
        add("rel",      1, 2'b01, 0, 1, 1, 1, 0, 0, 2, 29, 0);
        add("col2",     1, 2'b01, 0, 0, 1, 1, 0, 1, 1, 30, 0);
        for (int i = 0; i < 4; i++)
            add("hit2",  1, 2'b01, 0, 1, 1, 1, 0, 0, 1, 30, 0);
        add("play",     1, 2'b01, 0, 1, 1, 1, 0, 0, 1, 30, 0);
        add("col3",     1, 2'b01, 0, 0, 1, 0, 0, 0, 0, 30, 0);
        add("over",     1, 2'b01, 1, 1, 1, 0, 0, 0, 0, 30, 0);
        add("over_ex",  0, 2'b00, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("start2",   1, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("goal1",    1, 2'b01, 0, 1, 0, 1, 0, 1, 3, 30, 1);
        for (int i = 0; i < 4; i++)
            add("ghit1", 1, 2'b01, 1, 1, 1, 1, 0, 0, 3, 30, 1);
        add("goal2",    1, 2'b01, 0, 1, 0, 1, 0, 1, 3, 30, 2);
        for (int i = 0; i < 4; i++)
            add("ghit2", 1, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 2);
        add("goal3",    1, 2'b01, 0, 1, 0, 1, 0, 1, 3, 30, 3);
        for (int i = 0; i < 4; i++)
            add("ghit3", 1, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 3);
        add("goal4",    1, 2'b01, 1, 1, 0, 0, 1, 0, 3, 30, 4);
        add("won",      1, 2'b01, 0, 1, 1, 0, 1, 0, 3, 30, 4);
        add("won_ex",   0, 2'b00, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("start3",   1, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("both",     1, 2'b01, 0, 0, 0, 1, 0, 1, 2, 30, 0);
        add("bhit",     1, 2'b01, 0, 1, 1, 1, 0, 0, 2, 30, 0);
        add("dropld",   0, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 0);
        add("idle",     0, 2'b01, 0, 1, 1, 1, 0, 0, 3, 30, 0);

        do_reset();
        chk_all("reset", 1, 0, 0, 3, 30, 0);

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].st, vecs[i].tick,
                 vecs[i].cn, vecs[i].gn);
            chk_all(vecs[i].name, vecs[i].e, vecs[i].w, vecs[i].r,
                    vecs[i].l, vecs[i].t, vecs[i].g);
        end

        // Timeout with spare lives, then timeout on the last life
        do_reset();
        step(1, 2'b01, 0, 1, 1);
        repeat (29) step(1, 2'b01, 1, 1, 1);
        chk("to.timer29", int'(bus.SC_ENDGAME_MONITOR_Timer_Out), 1);
        step(1, 2'b01, 1, 1, 1);
        chk_all("to1", 1, 0, 1, 2, 30, 0);
        repeat (4) step(1, 2'b01, 0, 1, 1);
        step(1, 2'b01, 0, 0, 1);
        chk_all("to_col", 1, 0, 1, 1, 30, 0);
        repeat (4) step(1, 2'b01, 0, 1, 1);
        repeat (29) step(1, 2'b01, 1, 1, 1);
        chk("to.timer_last", int'(bus.SC_ENDGAME_MONITOR_Timer_Out), 1);
        step(1, 2'b01, 1, 1, 1);
        chk_all("to_over", 0, 0, 0, 0, 0, 0);

        // Goal on the timeout tick: goal wins, no life lost
        do_reset();
        step(1, 2'b01, 0, 1, 1);
        repeat (29) step(1, 2'b01, 1, 1, 1);
        step(1, 2'b01, 1, 1, 0);
        chk_all("goal_to", 1, 0, 1, 3, 30, 1);

        // Asynchronous reset in the middle of PLAY
        do_reset();
        step(1, 2'b01, 0, 1, 1);
        step(1, 2'b01, 0, 0, 1);
        repeat (4) step(1, 2'b01, 0, 1, 1);
        repeat (3) step(1, 2'b01, 1, 1, 1);
        chk_all("pre_rst", 1, 0, 0, 2, 27, 0);
        bus.SC_ENDGAME_MONITOR_Tick_In = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1, 0, 0, 3, 30, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_endgame_monitor.md
Name: sc_endgame_monitor

Overview:
- Produces the active-low end-game signal that the main game state machine consumes. It sits at the other end of that interface.
- Watches the main FSM state code and load signal, plus frog collision and goal events from the playfield.
- Tracks lives, round timer and goals reached, and asserts end-game when lives run out or all goals are filled.
- Also drives a respawn pulse and the score/lives/timer values for the display path.

Parameters:
- STATE_DATAWIDTH, 2, width of the main FSM state code input
- LIVES_INIT, 3, lives loaded at game start
- LIVES_WIDTH, 2, width of the lives counter
- TIME_INIT, 30, round timer reload value, in Tick_In units
- TIME_WIDTH, 6, width of the round timer
- GOALS_TO_WIN, 4, goals needed to win
- GOAL_WIDTH, 3, width of the goal counter
- RESPAWN_CYCLES, 4, clock cycles spent in HIT before play resumes (minimum 1)

Ports:
- SC_ENDGAME_MONITOR_CLOCK_50  in  1  system clock
- SC_ENDGAME_MONITOR_RESET_InLow  in  1  asynchronous, active-low reset
- SC_ENDGAME_MONITOR_MainState_In  in  STATE_DATAWIDTH  main FSM state code: 00 await, 11 await_1, 01 game, 10 endgame
- SC_ENDGAME_MONITOR_LoadSignal_In  in  1  high while the main FSM is in game
- SC_ENDGAME_MONITOR_Tick_In  in  1  one-cycle timebase strobe
- SC_ENDGAME_MONITOR_Collision_InLow  in  1  frog hit, level, active low
- SC_ENDGAME_MONITOR_Goal_InLow  in  1  frog home, level, active low
- SC_ENDGAME_MONITOR_EndGameSignal_OutLow  out  1  registered, low while in OVER
- SC_ENDGAME_MONITOR_Win_Out  out  1  registered; 1 = game ended by goals, 0 = by lives
- SC_ENDGAME_MONITOR_Respawn_Out  out  1  registered one-cycle pulse
- SC_ENDGAME_MONITOR_Lives_Out  out  LIVES_WIDTH  current lives
- SC_ENDGAME_MONITOR_Timer_Out  out  TIME_WIDTH  current round timer
- SC_ENDGAME_MONITOR_Goals_Out  out  GOAL_WIDTH  goals reached

Behaviour:
- Reset (asynchronous, active low): state IDLE, EndGame=1, Win=0, Respawn=0, Lives=LIVES_INIT, Timer=TIME_INIT, Goals=0, edge registers=1.
- Events are detected on falling edges: input=0 while the registered previous value=1. The edge registers update every cycle in every state.
- All state and output updates happen on the same rising edge that sees the edge. There is no extra latency.
- IDLE:
  - Counters are held at their init values; EndGame=1.
  - Go to PLAY when LoadSignal_In=1 and MainState_In=01.
- PLAY:
  - Tick_In: Timer-1.
  - A collision edge, or a Tick_In with Timer=1, is a life loss.
  - Life loss with Lives>1: Lives-1, Timer=TIME_INIT, Respawn=1 for one cycle, go to HIT.
  - Life loss with Lives=1: Lives=0, go to OVER, EndGame=0, Win=0. Timer keeps its value, or is 0 on a timeout.
  - Goal edge: Goals+1, Timer=TIME_INIT, Respawn pulse, go to HIT.
  - If the goal edge brings Goals+1 to GOALS_TO_WIN: go to OVER instead, EndGame=0, Win=1, no Respawn pulse.
  - LoadSignal_In=0 (main FSM left the game): go to IDLE and reload the counters.
- HIT:
  - Timer frozen; collision and goal edges ignored. Edges stay tracked, so an input still held low after HIT does not re-fire.
  - Count RESPAWN_CYCLES clocks, then return to PLAY.
  - LoadSignal_In=0: go to IDLE.
- OVER:
  - EndGame held low; all counters frozen.
  - MainState_In=00: go to IDLE, EndGame=1, Win=0, counters reloaded.
- Simultaneous events, PLAY only:
  - Collision and goal: collision wins; the goal is dropped.
  - Collision and timeout: exactly one life lost.
  - Goal and timeout on the same edge: the goal wins; the timer reloads and no life is lost.
- Counter limits:
  - Lives never wrap below 0.
  - Goals saturate at GOALS_TO_WIN.
  - Timer never reads 0 in PLAY or HIT.
- Reset mid-game: immediate return to reset values, independent of the clock.

Decomposition:
- Shared package sc_game_pkg holds:
  - the main FSM state codes (AWAIT_0=00, GAME=01, END=10, AWAIT_1=11);
  - this block's state encoding (IDLE, PLAY, HIT, OVER, 2 bits);
  - LIVES_INIT, TIME_INIT and GOALS_TO_WIN defaults.
- One sub-module, sc_falledge_detector: a registered previous value plus a one-cycle falling-edge pulse, instantiated twice (collision, goal).

Test Plan:
- Reset low mid-PLAY -> all outputs at reset values immediately: EndGame=1, Lives=3, Timer=30, Goals=0.
- State 11 then 01 with Load=1, then three collision edges spaced more than 4 cycles apart:
  - Lives goes 3->2->1->0 and Respawn pulses twice.
  - EndGame falls on the edge of the third collision; Win=0.
  - Collisions arriving during HIT are ignored.
- PLAY with 30 Tick_In pulses -> life lost on the 30th tick: Lives=2, Timer=30, Respawn pulse.
  - With Lives=1, the 30th tick goes to OVER with Timer=0.
- Four goal edges -> Goals 1,2,3, then on the 4th: OVER, EndGame=0, Win=1, Goals=4, no Respawn pulse.
- Collision and goal edges in the same cycle with Lives=3, Goals=0 -> Lives=2, Goals=0.
- In OVER, MainState_In=00 -> IDLE on the next edge, EndGame=1, Lives=3. LoadSignal_In dropped during HIT -> IDLE.
